counter_cmd_arbiter: RTL
========================

Name: counter_cmd_arbiter

Overview:
Owns an up/down counter and serialises every command that can touch it. Three command sources feed it: host trigger-in pulses, front-panel buttons and a prescaled autocount tick. Commands are latched as sticky pending requests, arbitrated one per clock, and applied to the count. The block reports the count, the last grant and wrap events to wire-out and trigger-out endpoints.

Parameters:
WIDTH, 8, counter width in bits.
DIV_WIDTH, 24, prescaler width in bits.
DIV_LOAD, 24'h100000, prescaler reload value; the autocount tick period is DIV_LOAD+1 clocks.

Ports:
clk  input  1  single system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
host_trig  input  3  one-cycle pulses from a trigger-in: [0]=reset cmd, [1]=up, [2]=down.
btn  input  3  synchronized active-high button levels, same bit map; edge-detected internally.
autocount  input  1  level; enables prescaler ticks as up requests.
hold  input  1  level; blocks up/down/auto service, reset still served.
count  output  WIDTH  current counter value.
grant  output  2  source served last cycle: 0=none, 1=host, 2=button, 3=auto.
cmd_valid  output  1  one-cycle pulse when any command was applied.
wrap_up  output  1  one-cycle pulse on up from all-ones to 0.
wrap_down  output  1  one-cycle pulse on down from 0 to all-ones.
pend_host  output  3  host pending request bits.
pend_btn  output  3  button pending request bits.

Behaviour:
- Reset values (registered outputs, at the reset edge):
  - count=0, grant=0, cmd_valid=0, wrap_up=0, wrap_down=0, pend_host=0, pend_btn=0, pend_auto=0.
  - Prescaler loads DIV_LOAD, tick=0, rr_last=button (so host wins the first tie).
  - Button history register is loaded with 3'b111, so a button held through reset does not fire.
- Prescaler:
  - Decrements every clock.
  - When it reaches 0 it reloads DIV_LOAD and asserts tick for exactly the next cycle.
  - It runs regardless of autocount.
- Capture, at each edge:
  - pend_host |= host_trig.
  - pend_btn |= btn & ~btn_q; btn_q <= btn.
  - pend_auto |= tick & autocount.
- Same-edge set and service: if a bit is served and set again at the same edge, it stays 1. No request is lost, and repeated requests to a bit already pending merge into one.
- Arbitration, evaluated on the registered pend_* state; at most one command per cycle:
  1. Any pending reset (host or button): count<=0. Both reset pend bits clear (captures at that edge still win). grant = host if host had it, else button.
  2. Else if hold=1: nothing served, grant=0, cmd_valid=0, all pend bits retained.
  3. Else, choosing between host and button, each with a request among up/down:
     - If both have one, the source != rr_last wins.
     - If only one has one, that source wins.
     - rr_last <= winner.
     - Within the winning source, up takes priority over down. Only the served bit clears.
  4. Else if pend_auto: count+1, pend_auto clears, grant=3.
  5. Else idle: grant=0.
- Arithmetic: modulo 2^WIDTH.
  - wrap_up=1 when an up is applied with count=all-ones.
  - wrap_down=1 when a down is applied with count=0.
  - A reset command never pulses either wrap.
- Latency: a host_trig pulse in cycle c sets pend at the end of c. The count, grant and cmd_valid update at the end of c+1 if uncontested.
- A reset asserted mid-operation discards all pending requests and any in-flight tick.

Test Plan:
- Reset, then host_trig=3'b010 for 1 cycle -> pend_host[1]=1 next cycle; count=1, grant=1, cmd_valid=1 the cycle after; pend_host=0.
- count=8'hFF, host up -> count=0, wrap_up=1 for 1 cycle. Then host down -> count=8'hFF, wrap_down=1.
- Host up and btn[1] rising in the same cycle, from reset -> host served first (grant=1), button next cycle (grant=2); count +2 total.
- hold=1, then host up plus button up, then host reset -> reset served (count=0), ups stay pending. Release hold -> ups served on 2 consecutive cycles.
- DIV_LOAD=3, autocount=1, no other traffic -> count increments every 4 clocks with grant=3. A host up arriving in the same cycle as the tick is served first and the auto increment follows next cycle.
- btn=3'b010 held through reset -> no increment after reset. Release and press again -> exactly 1 increment per press.

Source files
------------

// File: rtl/counter_cmd_arbiter.sv
// ============================================================================
//  Module      : counter_cmd_arbiter
//  Description : Up/down counter whose reset/up/down commands from host
//                triggers, buttons and a prescaled autocount tick are latched
//                as sticky requests and served one per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_cmd_arbiter #(
    parameter int                   WIDTH     = 8,
    parameter int                   DIV_WIDTH = 24,
    parameter logic [DIV_WIDTH-1:0] DIV_LOAD  = 'h100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       host_trig,
    input  logic [2:0]       btn,
    input  logic             autocount,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       grant,
    output logic             cmd_valid,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic [2:0]       pend_host,
    output logic [2:0]       pend_btn
);

    localparam logic [1:0] c_GRANT_NONE = 2'd0;
    localparam logic [1:0] c_GRANT_HOST = 2'd1;
    localparam logic [1:0] c_GRANT_BTN  = 2'd2;
    localparam logic [1:0] c_GRANT_AUTO = 2'd3;

    localparam logic c_SRC_HOST = 1'b0;
    localparam logic c_SRC_BTN  = 1'b1;

    localparam int c_RST = 0;
    localparam int c_UP  = 1;

    localparam logic [2:0] c_MASK_UP = 3'b010;
    localparam logic [2:0] c_MASK_DN = 3'b100;

    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_tick;
    logic [2:0]           r_pend_host;
    logic [2:0]           r_pend_btn;
    logic                 r_pend_auto;
    logic [2:0]           r_btn_q;
    logic                 r_rr_last;
    logic [WIDTH-1:0]     r_count;
    logic [1:0]           r_grant;
    logic                 r_cmd_valid;
    logic                 r_wrap_up;
    logic                 r_wrap_down;

    logic       w_host_ud;
    logic       w_btn_ud;
    logic       w_win_btn;
    logic [2:0] w_sel;
    logic [2:0] w_mask;
    logic [2:0] w_clr_host;
    logic [2:0] w_clr_btn;
    logic       w_clr_auto;
    logic [1:0] w_grant;
    logic       w_op_rst;
    logic       w_op_up;
    logic       w_op_dn;
    logic       w_rr_next;

    assign w_host_ud = |r_pend_host[2:1];
    assign w_btn_ud  = |r_pend_btn[2:1];

    // Fixed priority: reset, then hold gate, then host/button round-robin, then auto.
    always_comb begin
        w_win_btn  = 1'b0;
        w_sel      = 3'b000;
        w_mask     = 3'b000;
        w_clr_host = 3'b000;
        w_clr_btn  = 3'b000;
        w_clr_auto = 1'b0;
        w_grant    = c_GRANT_NONE;
        w_op_rst   = 1'b0;
        w_op_up    = 1'b0;
        w_op_dn    = 1'b0;
        w_rr_next  = r_rr_last;

        if (r_pend_host[c_RST] || r_pend_btn[c_RST]) begin
            w_op_rst          = 1'b1;
            w_clr_host[c_RST] = 1'b1;
            w_clr_btn[c_RST]  = 1'b1;
            w_grant           = r_pend_host[c_RST] ? c_GRANT_HOST : c_GRANT_BTN;
        end else if (!hold) begin
            if (w_host_ud || w_btn_ud) begin
                w_win_btn = w_btn_ud && (!w_host_ud || (r_rr_last == c_SRC_HOST));
                w_sel     = w_win_btn ? r_pend_btn : r_pend_host;
                if (w_sel[c_UP]) begin
                    w_op_up = 1'b1;
                    w_mask  = c_MASK_UP;
                end else begin
                    w_op_dn = 1'b1;
                    w_mask  = c_MASK_DN;
                end
                if (w_win_btn) begin
                    w_clr_btn = w_mask;
                    w_grant   = c_GRANT_BTN;
                    w_rr_next = c_SRC_BTN;
                end else begin
                    w_clr_host = w_mask;
                    w_grant    = c_GRANT_HOST;
                    w_rr_next  = c_SRC_HOST;
                end
            end else if (r_pend_auto) begin
                w_op_up    = 1'b1;
                w_clr_auto = 1'b1;
                w_grant    = c_GRANT_AUTO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= DIV_LOAD;
            r_tick      <= 1'b0;
            r_pend_host <= 3'b000;
            r_pend_btn  <= 3'b000;
            r_pend_auto <= 1'b0;
            r_btn_q     <= 3'b111;
            r_rr_last   <= c_SRC_BTN;
            r_count     <= '0;
            r_grant     <= c_GRANT_NONE;
            r_cmd_valid <= 1'b0;
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
        end else begin
            if (r_div == '0) begin
                r_div  <= DIV_LOAD;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div - DIV_WIDTH'(1);
                r_tick <= 1'b0;
            end

            // Clear-then-set so a bit re-requested on its service edge survives.
            r_pend_host <= (r_pend_host & ~w_clr_host) | host_trig;
            r_pend_btn  <= (r_pend_btn & ~w_clr_btn) | (btn & ~r_btn_q);
            r_pend_auto <= (r_pend_auto & ~w_clr_auto) | (r_tick & autocount);
            r_btn_q     <= btn;
            r_rr_last   <= w_rr_next;

            r_grant     <= w_grant;
            r_cmd_valid <= w_op_rst | w_op_up | w_op_dn;
            r_wrap_up   <= w_op_up && (r_count == '1);
            r_wrap_down <= w_op_dn && (r_count == '0);

            if (w_op_rst) begin
                r_count <= '0;
            end else if (w_op_up) begin
                r_count <= r_count + WIDTH'(1);
            end else if (w_op_dn) begin
                r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign count     = r_count;
    assign grant     = r_grant;
    assign cmd_valid = r_cmd_valid;
    assign wrap_up   = r_wrap_up;
    assign wrap_down = r_wrap_down;
    assign pend_host = r_pend_host;
    assign pend_btn  = r_pend_btn;

endmodule

`default_nettype wire
